mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 112 +++++++++++
 tb/tb_mem_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Single-port memory arbiter between an instruction-fetch and a data requester.
// Optional fetch-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        stallF,
  output logic        stallM,
  output logic        err
);

  // state  | meaning
  // IDLE   | port free; also the turnaround cycle between grants
  // DGRANT | data requester owns the memory port
  // IGRANT | fetch requester owns the memory port
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t      state, state_nxt;
  logic [15:0] addr_q, wdata_q;
  logic        wr_q, flush_pend, err_q;
  logic        dm_any, take_fetch;

  assign dm_any = dm_rd | dm_wr;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [1:0] starve_cnt;

  // After three data grants that kept a fetch waiting, the fetch goes first.
  assign take_fetch = if_req & (~dm_any | (starve_cnt == 2'd3));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 2'd0;
    end else if (state == IDLE && state_nxt == IGRANT) begin
      starve_cnt <= 2'd0;
    end else if (state == IDLE && state_nxt == DGRANT && if_req && starve_cnt != 2'd3) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end
`else
  assign take_fetch = if_req & ~dm_any;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_fetch)  state_nxt = IGRANT;
        else if (dm_any) state_nxt = DGRANT;
      end
      DGRANT, IGRANT: begin
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      wr_q       <= 1'b0;
      flush_pend <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == DGRANT) begin
        addr_q  <= dm_addr;
        wr_q    <= dm_wr;
        wdata_q <= dm_wdata;
        if (dm_rd && dm_wr) err_q <= 1'b1;
      end else if (state == IDLE && state_nxt == IGRANT) begin
        addr_q  <= if_addr;
        wr_q    <= 1'b0;
        wdata_q <= 16'h0000;
      end
      // A flushed fetch still completes on the bus; only its result is dropped.
      if (state == IGRANT && state_nxt != IGRANT) flush_pend <= 1'b0;
      else if (state == IGRANT && if_flush)       flush_pend <= 1'b1;
    end
  end

  assign mem_req   = (state == DGRANT) | (state == IGRANT);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dm_done   = (state == DGRANT) & mem_done;
  assign if_done   = (state == IGRANT) & mem_done & ~flush_pend;
  assign dm_rdata  = mem_rdata;
  assign if_rdata  = mem_rdata;
  assign stallM    = dm_any & ~dm_done;
  assign stallF    = if_req & ~if_done;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed, table-driven bench for mem_arb; starvation-guard expectations
// follow whether MEM_ARB_STARVE_GUARD_EN is defined.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst, if_req, if_flush, dm_rd, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_req, mem_wr, if_done, dm_done, stallF, stallM, err;
  logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_done(if_done), .if_rdata(if_rdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .stallF(stallF), .stallM(stallM), .err(err)
  );

  // ctl = {rst, if_req, if_flush, dm_rd, dm_wr, mem_done}
  // flg = {mem_req, mem_wr, if_done, dm_done, stallF, stallM, err}
  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] if_addr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] rdata;
    logic [6:0]  flg;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  logic [70:0] act, exp_v;
  logic [15:0] starve_exp;

  initial begin
    // reset / fetch-only with done three cycles after mem_req
    vecs[0]  = '{6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000};
    vecs[1]  = '{6'b010000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 7'b0000100, 16'h0000, 16'h0000};
    vecs[2]  = '{6'b010000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 7'b1000100, 16'h0040, 16'h0000};
    vecs[3]  = '{6'b010000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 7'b1000100, 16'h0040, 16'h0000};
    vecs[4]  = '{6'b010000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 7'b1000100, 16'h0040, 16'h0000};
    vecs[5]  = '{6'b010001, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 7'b1010000, 16'h0040, 16'h0000};
    vecs[6]  = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0040, 16'h0000};
    // simultaneous write + fetch: data first, inputs change while granted, turnaround
    vecs[7]  = '{6'b010010, 16'h0040, 16'h1000, 16'hBEEF, 16'h0000, 7'b0000110, 16'h0040, 16'h0000};
    vecs[8]  = '{6'b010010, 16'h0040, 16'h2222, 16'h0000, 16'h0000, 7'b1100110, 16'h1000, 16'hBEEF};
    vecs[9]  = '{6'b010011, 16'h0040, 16'h2222, 16'h0000, 16'h7777, 7'b1101100, 16'h1000, 16'hBEEF};
    vecs[10] = '{6'b010000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 7'b0100100, 16'h1000, 16'hBEEF};
    // fetch flushed in flight, then a stray done in IDLE
    vecs[11] = '{6'b011000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 7'b1000100, 16'h0080, 16'h0000};
    vecs[12] = '{6'b010000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 7'b1000100, 16'h0080, 16'h0000};
    vecs[13] = '{6'b010001, 16'h0080, 16'h0000, 16'h0000, 16'h5555, 7'b1000100, 16'h0080, 16'h0000};
    vecs[14] = '{6'b000001, 16'h0000, 16'h0000, 16'h0000, 16'h9999, 7'b0000000, 16'h0080, 16'h0000};
    vecs[15] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0080, 16'h0000};
    // reset mid-DGRANT, stray done afterwards
    vecs[16] = '{6'b000100, 16'h0000, 16'h3000, 16'h0000, 16'h0000, 7'b0000010, 16'h0080, 16'h0000};
    vecs[17] = '{6'b100100, 16'h0000, 16'h3000, 16'h0000, 16'h0000, 7'b1000010, 16'h3000, 16'h0000};
    vecs[18] = '{6'b000001, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 7'b0000000, 16'h0000, 16'h0000};
    // read+write together: served as write, err sticky until reset
    vecs[19] = '{6'b000110, 16'h0000, 16'h4000, 16'hA5A5, 16'h0000, 7'b0000010, 16'h0000, 16'h0000};
    vecs[20] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b1100001, 16'h4000, 16'hA5A5};
    vecs[21] = '{6'b000001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b1101001, 16'h4000, 16'hA5A5};
    vecs[22] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0100001, 16'h4000, 16'hA5A5};
    vecs[23] = '{6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0100001, 16'h4000, 16'hA5A5};
    vecs[24] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000};

    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; mem_done = 1'b0;
    if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      {rst, if_req, if_flush, dm_rd, dm_wr, mem_done} = vecs[i].ctl;
      if_addr   = vecs[i].if_addr;
      dm_addr   = vecs[i].dm_addr;
      dm_wdata  = vecs[i].dm_wdata;
      mem_rdata = vecs[i].rdata;
      #1;
      act   = {mem_req, mem_wr, if_done, dm_done, stallF, stallM, err,
               mem_addr, mem_wdata, if_rdata, dm_rdata};
      exp_v = {vecs[i].flg, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].rdata, vecs[i].rdata};
      checks++;
      if (act === exp_v) passed++;
      else $display("FAIL vec%0d: got %h expected %h", i, act, exp_v);
    end

    // Starvation sequence: data read and fetch both held across four grants.
    @(negedge clk);
    rst = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
    dm_rd = 1'b1; dm_wr = 1'b0; dm_addr = 16'h5000; if_req = 1'b1; if_addr = 16'h6000;
    #1;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      while (!mem_req && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_exp = (g == 3) ? 16'h6000 : 16'h5000;
`else
      starve_exp = 16'h5000;
`endif
      checks++;
      if (!mem_req)
        $display("FAIL starve_grant%0d: no mem_req within 10 cycles", g);
      else if (mem_addr === starve_exp)
        passed++;
      else
        $display("FAIL starve_grant%0d: mem_addr got %h expected %h", g, mem_addr, starve_exp);
      mem_done = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
      #1;
    end

    dm_rd = 1'b0; if_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
